uart_test_monitor: RTL and testbench

UART_TEST_MONITOR -- requirements
Module: uart_test_monitor

---
 rtl/uart_test_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_uart_test_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_test_monitor.sv
// -----------------------------------------------------------------------------
// uart_test_monitor
//
// Passive 8N1 UART receiver that watches a serial line, reports every
// correctly framed byte, flags bad stop bits, and (optionally) scans the
// received byte stream for the ASCII words "PASS" and "FAIL".
//
// Parameters
//   CLOCK_FREQUENCY : clock frequency in Hz
//   UART_BAUD_RATE  : expected line bit rate; CLOCK_FREQUENCY/UART_BAUD_RATE
//                     must be at least 4
//
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   uart_rx        in   serial line (idle high, 8N1)
//   rx_data        out  last correctly framed byte
//   rx_valid       out  one-cycle pulse when rx_data is updated
//   framing_error  out  one-cycle pulse on a bad stop bit
//   error_count    out  saturating (at 255) count of framing errors
//   busy           out  high whenever the receive FSM is not IDLE
//   test_passed    out  sticky: "PASS" seen in the byte stream
//   test_failed    out  sticky: "FAIL" seen in the byte stream
//
// Build option
//   UART_TEST_MONITOR_MATCH_EN : when defined, the 4-byte "PASS"/"FAIL"
//   matcher is built; otherwise test_passed and test_failed are tied low.
//   Receiver behaviour is the same either way.
//
// Debug: the receive FSM state is held in state_q (type rx_state_e).
// -----------------------------------------------------------------------------
module uart_test_monitor #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic [7:0] error_count,
    output logic       busy,
    output logic       test_passed,
    output logic       test_failed
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Two-flop synchronizer plus one more flop to remember the previous
    // synchronized level for falling-edge detection.
    logic sync1_q, sync2_q, prev_q;
    logic fall;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       err_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge, not level: a line stuck low can never start a second frame.
    assign fall = prev_q & ~sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                // Mid-start-bit check; a high level here means a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};  // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (ferr_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = ferr_q;
    assign error_count   = err_cnt_q;
    assign busy          = (state_q != IDLE);

`ifdef UART_TEST_MONITOR_MATCH_EN
    localparam logic [31:0] WORD_PASS = 32'h5041_5353;
    localparam logic [31:0] WORD_FAIL = 32'h4641_494C;

    // Oldest byte in the top byte lane; newest byte enters at the bottom.
    logic [31:0] window_q;
    logic [31:0] window_next;
    logic        passed_q, failed_q;

    assign window_next = {window_q[23:0], rx_data_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window_q <= '0;
            passed_q <= 1'b0;
            failed_q <= 1'b0;
        end else if (ferr_q) begin
            // A corrupted byte breaks any word in progress.
            window_q <= '0;
        end else if (rx_valid_q) begin
            window_q <= window_next;
            if (window_next == WORD_PASS) passed_q <= 1'b1;
            if (window_next == WORD_FAIL) failed_q <= 1'b1;
        end
    end

    assign test_passed = passed_q;
    assign test_failed = failed_q;
`else
    assign test_passed = 1'b0;
    assign test_failed = 1'b0;
`endif

endmodule

// File: tb/tb_uart_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_uart_test_monitor
//
// Directed bench for uart_test_monitor at 1 MHz / 100 kbaud (10 clocks/bit).
// Inputs are driven on the falling clock edge; outputs are sampled on the
// falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_uart_test_monitor;

    localparam int CPB = 10;

`ifdef UART_TEST_MONITOR_MATCH_EN
    localparam logic MATCH = 1'b1;
`else
    localparam logic MATCH = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic [7:0] error_count;
    logic       busy;
    logic       test_passed;
    logic       test_failed;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;
    logic [7:0] exp_data;
    int v0, f0;

    uart_test_monitor #(
        .CLOCK_FREQUENCY(1000000),
        .UART_BAUD_RATE (100000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .error_count  (error_count),
        .busy         (busy),
        .test_passed  (test_passed),
        .test_failed  (test_failed)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts pulses, checks exclusivity and one-cycle width.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) valid_cnt++;
            if (framing_error) ferr_cnt++;
            if (rx_valid || framing_error) begin
                chk("pulse_exclusive", 32'(rx_valid && framing_error), 32'd0);
                chk("pulse_width", 32'((rx_valid && prev_v) || (framing_error && prev_f)), 32'd0);
            end
            prev_v = rx_valid;
            prev_f = framing_error;
        end else begin
            prev_v = 1'b0;
            prev_f = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    // Entered and left on a falling edge. Sends start, 8 data bits LSB first,
    // a stop bit of the given level, then returns the line to idle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while ((busy !== lvl) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_pulse_passed", 32'(test_passed), 32'd0);
        chk("rst_pulse_failed", 32'(test_failed), 32'd0);
        chk("rst_pulse_errcnt", 32'(error_count), 32'd0);
        chk("rst_pulse_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        exp_data = 8'h00;
        repeat (3) @(negedge clock);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        uart_rx = 1'b1;
        exp_data = 8'h00;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(framing_error), 32'd0);
        chk("rst_errcnt", 32'(error_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_passed", 32'(test_passed), 32'd0);
        chk("rst_failed", 32'(test_failed), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Good byte 0xA5
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        exp_data = 8'hA5;
        chk("a5_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("a5_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
        chk("a5_data", 32'(rx_data), 32'(exp_data));
        chk("a5_errcnt", 32'(error_count), 32'd0);
        chk("a5_busy", 32'(busy), 32'd0);

        // Bad stop bit on 0x3C
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        chk("3c_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        chk("3c_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("3c_errcnt", 32'(error_count), 32'd1);
        chk("3c_data_kept", 32'(rx_data), 32'(exp_data));

        // 3-cycle low glitch on an idle line
        v0 = valid_cnt; f0 = ferr_cnt;
        uart_rx = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        wait_busy(1'b1, 10, "glitch_busy_rise");
        wait_busy(1'b0, 20, "glitch_busy_fall");
        repeat (5) @(negedge clock);
        chk("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // "PA", corrupted byte, "SS": the corrupted byte wipes the window
        send_byte(8'h50, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h53, 1'b0);
        send_byte(8'h53, 1'b1);
        send_byte(8'h53, 1'b1);
        exp_data = 8'h53;
        chk("broken_passed", 32'(test_passed), 32'd0);
        chk("broken_errcnt", 32'(error_count), 32'd2);
        chk("broken_data", 32'(rx_data), 32'(exp_data));

        // "xPASS" then "FAIL"
        send_byte(8'h78, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h53, 1'b1);
        chk("pas_not_yet", 32'(test_passed), 32'd0);
        send_byte(8'h53, 1'b1);
        chk("pass_passed", 32'(test_passed), 32'(MATCH));
        chk("pass_failed", 32'(test_failed), 32'd0);
        send_byte(8'h46, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h49, 1'b1);
        send_byte(8'h4C, 1'b1);
        exp_data = 8'h4C;
        chk("fail_passed", 32'(test_passed), 32'(MATCH));
        chk("fail_failed", 32'(test_failed), 32'(MATCH));
        chk("fail_data", 32'(rx_data), 32'(exp_data));

        // Reset clears sticky flags and the error counter
        pulse_reset();

        // 300 bad-stop frames: counter reaches 255 and stays there
        for (int i = 0; i < 254; i++) send_byte(8'h3C, 1'b0);
        chk("sat_errcnt_254", 32'(error_count), 32'd254);
        send_byte(8'h3C, 1'b0);
        chk("sat_errcnt_255", 32'(error_count), 32'd255);
        for (int i = 0; i < 45; i++) send_byte(8'h3C, 1'b0);
        chk("sat_errcnt_hold", 32'(error_count), 32'd255);
        chk("sat_data_kept", 32'(rx_data), 32'(exp_data));

        // Reset in the middle of bit 4 of a frame, then a clean 0x5A
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'(8'h5A >> i);
            repeat (CPB) @(negedge clock);
        end
        uart_rx = 1'b1;
        repeat (3) @(negedge clock);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_data = 8'h00;
        v0 = valid_cnt; f0 = ferr_cnt;
        repeat (120) @(negedge clock);
        chk("midrst_no_pulse", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
        send_byte(8'h5A, 1'b1);
        exp_data = 8'h5A;
        chk("midrst_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("midrst_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'(exp_data));
        chk("midrst_errcnt", 32'(error_count), 32'd0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
